// File: rtl/pmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pmem_responder
//  Purpose  : Line-granular backing store answering the cache pmem handshake
//             after a fixed latency.
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter int LINES   = 64,
    parameter int LATENCY = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         proto_error
);

    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_op_write;
    logic [c_IDX_W-1:0]  r_index;
    logic [127:0]        r_wdata;
    logic [127:0]        r_rdata;
    logic                r_proto_error;
    logic [127:0]        r_mem [LINES];

    logic                w_req;
    logic                w_op_held;
    logic [c_IDX_W-1:0]  w_req_index;
    logic [c_IDX_W-1:0]  w_rd_index;
    logic                w_is_read_op;
    logic                w_load_rdata;
    logic                w_unused_addr;

    assign w_req         = pmem_read | pmem_write;
    assign w_req_index   = pmem_address[4 +: c_IDX_W];
    assign w_op_held     = r_op_write ? pmem_write : pmem_read;
    assign w_unused_addr = ^pmem_address;

    // With LATENCY==1 the read is issued straight from IDLE, so the line index
    // and op come from the live request rather than the latched copies.
    assign w_rd_index   = (r_state == c_IDLE) ? w_req_index : r_index;
    assign w_is_read_op = (r_state == c_IDLE) ? ~pmem_write : ~r_op_write;
    assign w_load_rdata = (w_next_state == c_RESP) && w_is_read_op;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_next_state = (LATENCY > 1) ? c_BUSY : c_RESP;
                end
            end
            c_BUSY: begin
                if (!w_op_held) begin
                    w_next_state = c_IDLE;
                end else if (r_count == c_CNT_W'(1)) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_op_write    <= 1'b0;
            r_index       <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_proto_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_IDLE && w_req) begin
                r_op_write <= pmem_write;
                r_index    <= w_req_index;
                r_wdata    <= pmem_wdata;
                r_count    <= c_CNT_W'(LATENCY - 1);
                if (pmem_read && pmem_write) begin
                    r_proto_error <= 1'b1;
                end
            end else if (r_state == c_BUSY) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_load_rdata) begin
                r_rdata <= r_mem[w_rd_index];
            end
        end
    end

    // Storage is never cleared; a write lands only on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (!rst && r_state == c_RESP && r_op_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign pmem_resp   = (r_state == c_RESP);
    assign pmem_rdata  = r_rdata;
    assign busy        = (r_state != c_IDLE);
    assign proto_error = r_proto_error;

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_responder
//  Purpose  : Directed plus randomized checking of pmem_responder against a
//             line-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_responder;

    localparam int c_LAT   = 5;
    localparam int c_LINES = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp, busy, proto_error;
    logic [127:0] pmem_rdata;

    logic [2:0]   sw_read;
    logic [2:0]   sw_resp, sw_busy, sw_perr;
    logic [127:0] sw_rdata [3];

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] model_mem [c_LINES];
    logic [127:0] model_rdata;
    logic         model_perr;

    always #5 clk = ~clk;

    pmem_responder #(.LINES(c_LINES), .LATENCY(c_LAT)) dut (
        .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .busy(busy),
        .proto_error(proto_error)
    );

    pmem_responder #(.LINES(c_LINES), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .pmem_read(sw_read[0]), .pmem_write(1'b0),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(sw_resp[0]), .pmem_rdata(sw_rdata[0]), .busy(sw_busy[0]),
        .proto_error(sw_perr[0])
    );

    pmem_responder #(.LINES(c_LINES), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .pmem_read(sw_read[1]), .pmem_write(1'b0),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(sw_resp[1]), .pmem_rdata(sw_rdata[1]), .busy(sw_busy[1]),
        .proto_error(sw_perr[1])
    );

    pmem_responder #(.LINES(c_LINES), .LATENCY(7)) dut_l7 (
        .clk(clk), .rst(rst), .pmem_read(sw_read[2]), .pmem_write(1'b0),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(sw_resp[2]), .pmem_rdata(sw_rdata[2]), .busy(sw_busy[2]),
        .proto_error(sw_perr[2])
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request starting in a fresh cycle; held until the response, then dropped.
    task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [127:0] data);
        int lat;
        int busy_gaps;
        int idx;
        @(posedge clk); #1;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = data;
        idx          = int'(addr[9:4]);
        if (rd && wr) model_perr = 1'b1;
        lat       = 0;
        busy_gaps = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            pmem_address = 16'($urandom);
            pmem_wdata   = rnd128();
            if (pmem_resp) lat = c;
            else if (!busy) busy_gaps++;
        end
        check("latency", 128'(lat), 128'(c_LAT));
        check("busy_before_resp", 128'(busy_gaps), 128'(0));
        if (!wr) model_rdata = model_mem[idx];
        check("rdata", pmem_rdata, model_rdata);
        check("proto_error", 128'(proto_error), 128'(model_perr));
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (wr) model_mem[idx] = data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] a, b, c_data;
        int           sw_lat [3];
        bit           saw;
        sw_lat       = '{1, 2, 7};
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        sw_read      = '0;
        model_rdata  = '0;
        model_perr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", 128'(pmem_resp), 128'(0));
        check("reset_rdata", pmem_rdata, 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_perr", 128'(proto_error), 128'(0));
        rst = 1'b0;

        // Give every line a known value so later reads are fully predictable.
        for (int i = 0; i < c_LINES; i++) txn(1'b0, 1'b1, 16'(i << 4), rnd128());

        txn(1'b0, 1'b1, 16'h0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        txn(1'b1, 1'b0, 16'h004E, '0);
        check("plan_rd_0040", pmem_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        a = rnd128();
        txn(1'b0, 1'b1, 16'h0100, a);
        txn(1'b1, 1'b0, 16'h0100, '0);
        check("b2b_rd_0100", pmem_rdata, a);

        b = rnd128();
        txn(1'b0, 1'b1, 16'h0400, b);
        txn(1'b1, 1'b0, 16'h0000, '0);
        check("alias_rd_0000", pmem_rdata, b);

        txn(1'b1, 1'b1, 16'h0010, rnd128());
        txn(1'b1, 1'b0, 16'h0010, '0);
        check("perr_sticky", 128'(proto_error), 128'(1));

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) txn(1'b1, 1'b0, 16'($urandom), '0);
            else txn(1'b0, 1'b1, 16'($urandom), rnd128());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        // Abort: read dropped during cycle 2.
        @(posedge clk); #1;
        pmem_read    = 1'b1;
        pmem_address = 16'($urandom);
        @(posedge clk); #1;
        check("abort_busy_c1", 128'(busy), 128'(1));
        @(posedge clk); #1;
        pmem_read = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_c3", 128'(busy), 128'(0));
        saw = pmem_resp;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (pmem_resp) saw = 1'b1;
        end
        check("abort_no_resp", 128'(saw), 128'(0));
        check("abort_rdata_held", pmem_rdata, model_rdata);

        // Reset lands at the end of cycle 3 of a write.
        c_data = rnd128();
        @(posedge clk); #1;
        pmem_write   = 1'b1;
        pmem_address = 16'h0200;
        pmem_wdata   = c_data;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        pmem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_resp", 128'(pmem_resp), 128'(0));
        check("rst_rdata", pmem_rdata, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_perr", 128'(proto_error), 128'(0));
        model_perr  = 1'b0;
        model_rdata = '0;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (pmem_resp) saw = 1'b1;
        end
        check("rst_no_resp", 128'(saw), 128'(0));
        txn(1'b1, 1'b0, 16'h0200, '0);

        // Latency sweep across LATENCY 1, 2 and 7 instances.
        @(posedge clk); #1;
        pmem_address = 16'($urandom);
        sw_read      = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sweep_busy_l%0d_c%0d", sw_lat[i], c),
                      128'(sw_busy[i]), 128'(c <= sw_lat[i]));
                check($sformatf("sweep_resp_l%0d_c%0d", sw_lat[i], c),
                      128'(sw_resp[i]), 128'(c == sw_lat[i]));
                if (c == sw_lat[i]) sw_read[i] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory responder for the cache's pmem line interface: the far end of the pmem_read/pmem_write/pmem_resp handshake.
- Stores 128-bit lines. Services one line read or line write per request after a fixed, parameterised latency.
- Used as a synthesizable backing store and as the bench memory beneath the cache in top-level simulation.

Parameters:
LINES, 64, number of 128-bit lines stored; power of two; index = pmem_address[4+log2(LINES)-1:4]
LATENCY, 5, cycles from request acceptance to pmem_resp; minimum 1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pmem_read  input  1  line read request, held until pmem_resp
pmem_write  input  1  line write request, held until pmem_resp
pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored
pmem_wdata  input  128  write line (lc3b_line)
pmem_resp  output  1  one-cycle completion pulse
pmem_rdata  output  128  read line (lc3b_line), valid in the pmem_resp cycle
busy  output  1  high while a request is in service (BUSY or RESP state)
proto_error  output  1  sticky; set when pmem_read and pmem_write are sampled high together in IDLE

Behaviour:
- Reset (rst high at an edge): state=IDLE, counter=0, pmem_resp=0, pmem_rdata=0, busy=0, proto_error=0. Memory array contents are NOT cleared. Reset overrides any in-flight request; no response is issued and no write is committed.
- States: IDLE, BUSY, RESP.
- IDLE, request seen:
  - If pmem_read or pmem_write is high at an edge: latch op, line index, and wdata; counter=LATENCY-1.
  - Go to BUSY if LATENCY>1, else RESP.
- IDLE, simultaneous read and write: set proto_error, service as a write.
- BUSY: decrement counter each edge. Go to RESP on the edge where counter==1.
- Latency: request first high in cycle 0 (accepted at the end of cycle 0) -> pmem_resp high during cycle LATENCY exactly.
- Abort: if the latched op's request signal is sampled low in BUSY, return to IDLE. No resp, no write, no rdata update.
- RESP cycle, outputs:
  - pmem_resp=1 for exactly one cycle.
  - Read: pmem_rdata = mem[latched index], registered on the edge entering RESP.
  - Write: pmem_rdata unchanged.
- RESP cycle, write commit: mem[latched index] = latched wdata on the edge leaving RESP.
- RESP always returns to IDLE.
- Back-to-back: a request high in the cycle after RESP is accepted as new. The initiator must deassert or switch request in that cycle, or it is re-serviced.
- Latching: address and wdata changes after acceptance are ignored.
- Read-after-write to the same line in the next request returns the new data.
- Addressing: bits above the index alias (wrap). With LINES=64, 0x0400 maps to the same line as 0x0000. Bits [3:0] never affect behaviour.
- pmem_rdata holds its last read value outside RESP.
- busy = (state != IDLE).
- proto_error clears only on rst.

Test Plan:
- Write then read, LATENCY=5: write 0x0040, wdata=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> resp in cycle 5. Then read 0x004E -> resp in cycle 5 with the same line.
- Latency sweep LATENCY=1,2,7: single read -> exactly one pmem_resp, in cycle LATENCY after assertion; busy high from cycle 1 through the resp cycle.
- Back-to-back: write 0x0100 (data A), deassert write and assert read 0x0100 in the next cycle -> read resp returns A, LATENCY cycles later, with no duplicate write resp.
- Aliasing/error, LINES=64:
  - Write 0x0400 (data B), read 0x0000 -> B.
  - Assert read+write together at 0x0010 -> proto_error=1, serviced as a write, and proto_error stays 1 until rst.
- Abort: read issued, read dropped in cycle 2 -> no pmem_resp, pmem_rdata unchanged, busy=0 in cycle 3.
- Mid-write reset: write 0x0200 (data C), rst in cycle 3 -> no pmem_resp, outputs zero, and a later read of 0x0200 returns the prior contents, not C.
